// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access size/sign codes,
// MMIO word offsets and a saturating counter helper.
package dmem_responder_pkg;

  localparam logic [2:0] DM_WORD              = 3'b000;
  localparam logic [2:0] DM_HALFWORD          = 3'b001;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
  localparam logic [2:0] DM_BYTE              = 3'b011;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

  // MMIO register selects, taken from addr[3:2]
  localparam logic [1:0] MMIO_LED    = 2'd0;
  localparam logic [1:0] MMIO_CYCLE  = 2'd1;
  localparam logic [1:0] MMIO_STATUS = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering: byte enables and replicated store data for stores,
// lane extraction plus sign/zero extension for loads, and an alignment check.
module dmem_lane_unit
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rext,
  output logic        misalign
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;
  logic        sext_s;

  // Lane selection and extension; unknown types write nothing and count as misaligned
  always_comb begin
    half_s   = addr_lo[1] ? rword[31:16] : rword[15:0];
    sext_s   = 1'b0;
    byte_en  = 4'b0000;
    wword    = 32'h0000_0000;
    rext     = 32'h0000_0000;
    misalign = 1'b0;
    case (addr_lo)
      2'd0:    byte_s = rword[7:0];
      2'd1:    byte_s = rword[15:8];
      2'd2:    byte_s = rword[23:16];
      default: byte_s = rword[31:24];
    endcase
    case (dm_type)
      DM_WORD: begin
        byte_en  = 4'b1111;
        wword    = wdata;
        rext     = rword;
        misalign = (addr_lo != 2'b00);
      end
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: begin
        sext_s   = (dm_type == DM_HALFWORD) & half_s[15];
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rext     = {{16{sext_s}}, half_s};
        misalign = addr_lo[0];
      end
      DM_BYTE, DM_BYTE_UNSIGNED: begin
        sext_s   = (dm_type == DM_BYTE) & byte_s[7];
        byte_en  = 4'b0001 << addr_lo;
        wword    = {4{wdata[7:0]}};
        rext     = {{24{sext_s}}, byte_s};
        misalign = 1'b0;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the pipeline data port: word RAM with byte-lane stores,
// zero-latency extended loads, and an MMIO window (LED, CYCLE, STATUS).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DM_AW     = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_w,
  input  logic             mem_r,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [2:0]       dm_type,
  output logic [31:0]      rdata,
  input  logic [DM_AW-1:0] dbg_addr,
  output logic [31:0]      dbg_data,
  output logic [31:0]      led_out,
  output logic             err_irq
);

  logic [31:0] ram_r [0:(1<<DM_AW)-1];
  logic [31:0] led_r;
  logic [31:0] cycle_r;
  logic [1:0]  sticky_r;
  logic [7:0]  err_cnt_r;
  logic        err_irq_r;

  logic [DM_AW-1:0] word_idx_s;
  logic        in_ram_s, in_mmio_s, bad_align_s, unmapped_s, ok_s, err_s;
  logic        ram_we_s, led_we_s, stat_clr_s;
  logic [31:0] mmio_word_s, rword_s, wword_s, rext_s;
  logic [3:0]  byte_en_s;
  logic        lane_mis_s;
  logic [1:0]  sticky_nxt_s;
  logic [7:0]  err_cnt_nxt_s;

  assign word_idx_s = addr[DM_AW+1:2];
  assign dbg_data   = ram_r[dbg_addr];
  assign led_out    = led_r;
  assign err_irq    = err_irq_r;

  dmem_lane_unit u_lane (
    .dm_type  (dm_type),
    .addr_lo  (addr[1:0]),
    .wdata    (wdata),
    .rword    (rword_s),
    .byte_en  (byte_en_s),
    .wword    (wword_s),
    .rext     (rext_s),
    .misalign (lane_mis_s)
  );

  // Address decode, error classification, write strobes and load mux
  always_comb begin
    in_ram_s    = (addr[31:DM_AW+2] == {(30-DM_AW){1'b0}});
    in_mmio_s   = (addr[31:4] == MMIO_BASE[31:4]) && (addr[3:2] != 2'b11);
    case (addr[3:2])
      MMIO_LED:    mmio_word_s = led_r;
      MMIO_CYCLE:  mmio_word_s = cycle_r;
      MMIO_STATUS: mmio_word_s = {16'h0000, err_cnt_r, 6'b000000, sticky_r};
      default:     mmio_word_s = 32'h0000_0000;
    endcase
    rword_s     = in_mmio_s ? mmio_word_s : ram_r[word_idx_s];
    // MMIO registers only accept whole-word accesses
    bad_align_s = lane_mis_s | (in_mmio_s & (dm_type != DM_WORD));
    unmapped_s  = ~in_ram_s & ~in_mmio_s;
    ok_s        = ~bad_align_s & ~unmapped_s;
    err_s       = (mem_w | mem_r) & ~ok_s;
    ram_we_s    = mem_w & ok_s & in_ram_s & ~reset;
    led_we_s    = mem_w & ok_s & in_mmio_s & (addr[3:2] == MMIO_LED);
    stat_clr_s  = mem_w & ok_s & in_mmio_s & (addr[3:2] == MMIO_STATUS);
    rdata       = (mem_r & ok_s) ? rext_s : 32'h0000_0000;
    if (stat_clr_s) begin
      sticky_nxt_s  = 2'b00;
      err_cnt_nxt_s = 8'h00;
    end else if (err_s) begin
      sticky_nxt_s  = sticky_r | {unmapped_s, bad_align_s};
      err_cnt_nxt_s = sat_inc8(err_cnt_r);
    end else begin
      sticky_nxt_s  = sticky_r;
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  // RAM byte-lane writes; contents are never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we_s && byte_en_s[i]) begin
        ram_r[word_idx_s][8*i +: 8] <= wword_s[8*i +: 8];
      end
    end
  end

  // MMIO state: LED, free-running cycle counter, sticky status and error count
  always_ff @(posedge clk) begin
    if (reset) begin
      led_r     <= 32'h0000_0000;
      cycle_r   <= 32'h0000_0000;
      sticky_r  <= 2'b00;
      err_cnt_r <= 8'h00;
      err_irq_r <= 1'b0;
    end else begin
      cycle_r   <= cycle_r + 32'd1;
      if (led_we_s) begin
        led_r <= wdata;
      end
      sticky_r  <= sticky_nxt_s;
      err_cnt_r <= err_cnt_nxt_s;
      err_irq_r <= |sticky_nxt_s;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed checks of dmem_responder against a byte-level
// behavioural model of RAM, MMIO registers and error accounting.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int          DM_AW = 10;
  localparam int          NB    = 4 * (1 << DM_AW);
  localparam logic [31:0] MB    = 32'hFFFF_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mem_w = 1'b0, mem_r = 1'b0;
  logic [31:0]      addr = 32'h0, wdata = 32'h0;
  logic [2:0]       dm_type = DM_WORD;
  logic [31:0]      rdata, dbg_data, led_out;
  logic [DM_AW-1:0] dbg_addr = '0;
  logic             err_irq;

  dmem_responder #(.DM_AW(DM_AW), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .mem_r(mem_r), .addr(addr),
    .wdata(wdata), .dm_type(dm_type), .rdata(rdata), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .led_out(led_out), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  m_mem [0:NB-1];
  logic [31:0] m_led, m_cyc;
  logic [1:0]  m_bits;
  int          m_cnt;
  bit          dbg_chk = 1'b0;
  logic [DM_AW-1:0] dbg_sel = '0;

  function automatic int acc_size(input logic [2:0] t);
    case (t)
      DM_WORD:                           return 4;
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: return 2;
      DM_BYTE, DM_BYTE_UNSIGNED:         return 1;
      default:                           return 0;
    endcase
  endfunction

  function automatic logic [1:0] errs(input logic [31:0] a, input logic [2:0] t);
    int sz = acc_size(t);
    bit in_ram  = (a < NB);
    bit in_mmio = (a >= MB) && (a < MB + 32'd12);
    bit mis = (sz == 0) || ((a[1:0] & 2'(sz - 1)) != 2'b00) || (in_mmio && sz != 4);
    return {!in_ram && !in_mmio, mis};
  endfunction

  function automatic logic [31:0] model_word(input int idx);
    return {m_mem[4*idx+3], m_mem[4*idx+2], m_mem[4*idx+1], m_mem[4*idx]};
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a, input logic [2:0] t, input bit mr);
    int sz = acc_size(t);
    logic [31:0] v = 32'h0;
    if (!mr || errs(a, t) != 2'b00) return 32'h0;
    if (a < NB) begin
      for (int i = 0; i < sz; i++) v = v | (32'(m_mem[a + i]) << (8 * i));
      if ((t == DM_HALFWORD || t == DM_BYTE) && v[8*sz-1])
        v = v | ~((32'd1 << (8 * sz)) - 32'd1);
      return v;
    end
    case ((a - MB) >> 2)
      0:       return m_led;
      1:       return m_cyc;
      default: return {16'h0, 8'(m_cnt), 6'h0, m_bits};
    endcase
  endfunction

  task automatic model_edge(input bit mw, input bit mr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] t, input bit rst);
    logic [1:0] e;
    if (rst) begin
      m_led = 32'h0; m_cyc = 32'h0; m_bits = 2'b00; m_cnt = 0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      if (mw || mr) begin
        e = errs(a, t);
        if (e != 2'b00) begin
          m_bits = m_bits | e;
          if (m_cnt < 255) m_cnt++;
        end else if (mw) begin
          if (a < NB) begin
            for (int i = 0; i < acc_size(t); i++) m_mem[a + i] = wd[8*i +: 8];
          end else if (a == MB) begin
            m_led = wd;
          end else if (a == MB + 32'd8) begin
            m_bits = 2'b00; m_cnt = 0;
          end
        end
      end
    end
  endtask

  // One bus cycle: drive at the falling edge, check comb outputs, clock, check registers
  task automatic step(input bit mw, input bit mr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] t, input bit rst, output logic [31:0] got);
    mem_w = mw; mem_r = mr; addr = a; wdata = wd; dm_type = t; reset = rst; dbg_addr = dbg_sel;
    #1;
    got = rdata;
    check_val("rdata", rdata, model_rdata(a, t, mr));
    if (dbg_chk) check_val("dbg_data", dbg_data, model_word(int'(dbg_sel)));
    @(posedge clk);
    model_edge(mw, mr, a, wd, t, rst);
    @(negedge clk);
    check_val("led_out", led_out, m_led);
    check_val("err_irq", {31'h0, err_irq}, {31'h0, m_bits != 2'b00});
  endtask

  logic [31:0] g, c1, c2;
  logic [31:0] ra, rw;
  logic [2:0]  rt;
  int          r;

  initial begin
    @(negedge clk);
    step(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD, 1'b1, g);
    step(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD, 1'b1, g);
    check_val("rst_cycle_zero", dut.cycle_r, 32'h0);

    // Give the RAM words used later a known value
    for (int w = 0; w < 16; w++) step(1'b1, 1'b0, 32'(4 * w), $urandom, DM_WORD, 1'b0, g);
    step(1'b1, 1'b0, 32'h0FFC, $urandom, DM_WORD, 1'b0, g);
    dbg_chk = 1'b1;
    dbg_sel = 10'd4;

    step(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, DM_WORD, 1'b0, g);
    step(1'b0, 1'b1, 32'h10, 32'h0, DM_WORD, 1'b0, g);
    check_val("lw_rt", g, 32'hDEADBEEF);
    check_val("dbg4", dbg_data, 32'hDEADBEEF);
    step(1'b1, 1'b0, 32'h13, 32'h7F, DM_BYTE, 1'b0, g);
    step(1'b0, 1'b1, 32'h10, 32'h0, DM_WORD, 1'b0, g);
    check_val("sb_word", g, 32'h7FADBEEF);
    step(1'b0, 1'b1, 32'h12, 32'h0, DM_BYTE, 1'b0, g);              check_val("lb12", g, 32'hFFFFFFAD);
    step(1'b0, 1'b1, 32'h12, 32'h0, DM_BYTE_UNSIGNED, 1'b0, g);     check_val("lbu12", g, 32'h000000AD);
    step(1'b0, 1'b1, 32'h12, 32'h0, DM_HALFWORD, 1'b0, g);          check_val("lh12", g, 32'h00007FAD);
    step(1'b0, 1'b1, 32'h10, 32'h0, DM_HALFWORD_UNSIGNED, 1'b0, g); check_val("lhu10", g, 32'h0000BEEF);
    step(1'b0, 1'b1, 32'h10, 32'h0, DM_HALFWORD, 1'b0, g);          check_val("lh10", g, 32'hFFFFBEEF);

    step(1'b1, 1'b0, 32'h11, 32'h1, DM_WORD, 1'b0, g);
    check_val("mis_nowrite", dbg_data, 32'h7FADBEEF);
    check_val("mis_irq", {31'h0, err_irq}, 32'h1);
    step(1'b0, 1'b1, MB + 32'd8, 32'h0, DM_WORD, 1'b0, g);          check_val("status_mis", g, 32'h00000101);
    step(1'b0, 1'b1, 32'h12, 32'h0, DM_WORD, 1'b0, g);              check_val("mis_rdata", g, 32'h0);
    step(1'b1, 1'b0, MB + 32'd8, 32'h0, DM_WORD, 1'b0, g);
    check_val("clr_irq", {31'h0, err_irq}, 32'h0);
    step(1'b0, 1'b1, MB + 32'd8, 32'h0, DM_WORD, 1'b0, g);          check_val("status_clr", g, 32'h0);

    step(1'b0, 1'b1, 32'h8000_0000, 32'h0, DM_WORD, 1'b0, g);       check_val("unm_rdata", g, 32'h0);
    step(1'b0, 1'b1, MB + 32'd8, 32'h0, DM_WORD, 1'b0, g);          check_val("status_unm", g, 32'h00000102);
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 32'h8000_0000, 32'h0, DM_WORD, 1'b0, g);
    step(1'b0, 1'b1, MB + 32'd8, 32'h0, DM_WORD, 1'b0, g);          check_val("status_sat", g, 32'h0000FF02);
    step(1'b0, 1'b1, 32'h0000_1000, 32'h0, DM_WORD, 1'b0, g);       check_val("ram_end_unm", g, 32'h0);
    step(1'b1, 1'b0, MB + 32'd8, 32'h0, DM_WORD, 1'b0, g);

    step(1'b1, 1'b0, MB, 32'hA5, DM_WORD, 1'b0, g);
    check_val("led_a5", led_out, 32'hA5);
    step(1'b0, 1'b1, MB + 32'd4, 32'h0, DM_WORD, 1'b0, c1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD, 1'b0, g);
    step(1'b0, 1'b1, MB + 32'd4, 32'h0, DM_WORD, 1'b0, c2);
    check_val("cyc_diff", c2 - c1, 32'd6);
    step(1'b1, 1'b0, MB + 32'd4, 32'h0, DM_WORD, 1'b0, g);
    step(1'b0, 1'b1, MB + 32'd4, 32'h0, DM_WORD, 1'b0, g);
    check_val("cyc_ro", g - c2, 32'd2);

    force dut.cycle_r = 32'hFFFF_FFFF;
    #1 release dut.cycle_r;
    m_cyc = 32'hFFFF_FFFF;
    step(1'b0, 1'b1, MB + 32'd4, 32'h0, DM_WORD, 1'b0, g);          check_val("cyc_max", g, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, MB + 32'd4, 32'h0, DM_WORD, 1'b0, g);          check_val("cyc_wrap", g, 32'h0);

    step(1'b0, 1'b1, 32'h11, 32'h0, DM_HALFWORD, 1'b0, g);
    step(1'b1, 1'b0, MB, 32'h55, DM_WORD, 1'b1, g);
    check_val("rst_led", led_out, 32'h0);
    step(1'b0, 1'b1, MB + 32'd4, 32'h0, DM_WORD, 1'b0, g);          check_val("rst_cyc", g, 32'h0);
    step(1'b0, 1'b1, MB + 32'd8, 32'h0, DM_WORD, 1'b0, g);          check_val("rst_status", g, 32'h0);

    // Random traffic over the initialised RAM words, MMIO and unmapped space
    for (int n = 0; n < 500; n++) begin
      r  = int'($urandom_range(0, 9));
      rt = (r < 8) ? 3'(r) : DM_WORD;
      r  = int'($urandom_range(0, 99));
      if (r < 70)      ra = 32'($urandom_range(0, 63));
      else if (r < 78) ra = 32'h0FFC + 32'($urandom_range(0, 3));
      else if (r < 92) ra = MB + 32'($urandom_range(0, 15));
      else if (r < 96) ra = 32'h1000 + 32'($urandom_range(0, 7));
      else             ra = 32'h8000_0000;
      rw = $urandom;
      r  = int'($urandom_range(0, 15));
      dbg_sel = (r == 15) ? 10'd1023 : 10'(r);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rw, rt,
           ($urandom_range(0, 49) == 0), g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
